// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Purpose : Bundles the control, instruction-memory and status signals of the
//           instruction fetch unit so they travel as one port.
// Signals :
//   control (master -> slave) : pc_rst, pc_write, pc_sel, br_sel, ir_load
//   memory  (master -> slave) : imem_ack, imem_rdata[31:0]
//   memory  (slave -> master) : imem_req, imem_addr[15:0]
//   status  (slave -> master) : ir[31:0], opcode[3:0], mm[3:0], pc[15:0],
//                               fetch_busy, fetch_done, fetch_err
// Modports: master = sequencer / memory side, slave = fetch_unit.
// -----------------------------------------------------------------------------
interface fetch_unit_if;
  // Control from the sequencer
  logic        pc_rst;
  logic        pc_write;
  logic        pc_sel;
  logic        br_sel;
  logic        ir_load;

  // Instruction memory handshake
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  // Status / architectural state
  logic [31:0] ir;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [15:0] pc;
  logic        fetch_busy;
  logic        fetch_done;
  logic        fetch_err;

  modport master (
    output pc_rst, pc_write, pc_sel, br_sel, ir_load,
    output imem_ack, imem_rdata,
    input  imem_req, imem_addr,
    input  ir, opcode, mm, pc, fetch_busy, fetch_done, fetch_err
  );

  modport slave (
    input  pc_rst, pc_write, pc_sel, br_sel, ir_load,
    input  imem_ack, imem_rdata,
    output imem_req, imem_addr,
    output ir, opcode, mm, pc, fetch_busy, fetch_done, fetch_err
  );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Purpose : Program counter plus a three-state instruction fetch engine.
//           A fetch is started with ir_load in IDLE; the unit raises imem_req
//           with the PC as address and holds it until imem_ack, then loads the
//           word into ir and pulses fetch_done for one cycle.
// Ports   :
//   clk    in   system clock, all state updates on the rising edge
//   rst_f  in   synchronous active-low reset
//   bus    slave modport of fetch_unit_if (control, memory and status)
// Option  : define FETCH_TIMEOUT_EN to compile in a 16-cycle request timeout
//           that aborts the fetch and sets the sticky fetch_err flag. Without
//           it a request waits indefinitely and fetch_err is constant 0.
// All outputs come straight from registers (opcode/mm are slices of ir).
// -----------------------------------------------------------------------------
module fetch_unit (
  input  logic         clk,
  input  logic         rst_f,
  fetch_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [31:0] r_ir;
  logic        r_imem_req;
  logic [15:0] r_imem_addr;
  logic        r_fetch_busy;
  logic        r_fetch_done;

`ifdef FETCH_TIMEOUT_EN
  logic [3:0]  r_tmo_cnt;
  logic        r_fetch_err;
`endif

  // Next-PC selection. Relative targets add the low half of ir as a 16-bit
  // two's-complement offset; the 16-bit add wraps naturally, so a negative
  // offset needs no explicit sign handling.
  logic [15:0] w_pc_inc;
  logic [15:0] w_pc_rel;
  logic [15:0] w_pc_target;
  logic [15:0] w_pc_next;

  always_comb begin
    w_pc_inc    = r_pc + 16'd1;
    w_pc_rel    = r_pc + r_ir[15:0];
    w_pc_target = bus.br_sel ? r_ir[15:0] : w_pc_rel;
    w_pc_next   = bus.pc_sel ? w_pc_target : w_pc_inc;
  end

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      r_state      <= IDLE;
      r_pc         <= 16'h0000;
      r_ir         <= 32'h0000_0000;
      r_imem_req   <= 1'b0;
      r_imem_addr  <= 16'h0000;
      r_fetch_busy <= 1'b0;
      r_fetch_done <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      r_tmo_cnt    <= 4'd0;
      r_fetch_err  <= 1'b0;
`endif
    end else if (bus.pc_rst) begin
      // Aborts any fetch in flight; ir and imem_addr deliberately keep their
      // values so the last instruction stays visible.
      r_state      <= IDLE;
      r_pc         <= 16'h0000;
      r_imem_req   <= 1'b0;
      r_fetch_busy <= 1'b0;
      r_fetch_done <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      r_tmo_cnt    <= 4'd0;
      r_fetch_err  <= 1'b0;
`endif
    end else begin
      r_fetch_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // pc_write and ir_load together: the fetch uses the PC before the
          // update because r_imem_addr samples the current r_pc.
          if (bus.pc_write) begin
            r_pc <= w_pc_next;
          end
          if (bus.ir_load) begin
            r_state      <= REQ;
            r_imem_addr  <= r_pc;
            r_imem_req   <= 1'b1;
            r_fetch_busy <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            r_tmo_cnt    <= 4'd0;
`endif
          end
        end

        REQ: begin
          // pc_write and ir_load are not looked at here: busy ignores them.
          if (bus.imem_ack) begin
            r_ir         <= bus.imem_rdata;
            r_imem_req   <= 1'b0;
            r_fetch_done <= 1'b1;
            r_state      <= DONE;
          end
`ifdef FETCH_TIMEOUT_EN
          // Counter holds 15 during the 16th request cycle; no ack by then
          // abandons the fetch without touching ir or fetch_done.
          else if (r_tmo_cnt == 4'hF) begin
            r_fetch_err  <= 1'b1;
            r_imem_req   <= 1'b0;
            r_fetch_busy <= 1'b0;
            r_state      <= IDLE;
          end else begin
            r_tmo_cnt    <= r_tmo_cnt + 4'd1;
          end
`endif
        end

        DONE: begin
          r_fetch_busy <= 1'b0;
          r_state      <= IDLE;
        end

        default: begin
          r_imem_req   <= 1'b0;
          r_fetch_busy <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.pc         = r_pc;
  assign bus.ir         = r_ir;
  assign bus.opcode     = r_ir[31:28];
  assign bus.mm         = r_ir[27:24];
  assign bus.imem_req   = r_imem_req;
  assign bus.imem_addr  = r_imem_addr;
  assign bus.fetch_busy = r_fetch_busy;
  assign bus.fetch_done = r_fetch_done;
`ifdef FETCH_TIMEOUT_EN
  assign bus.fetch_err  = r_fetch_err;
`else
  assign bus.fetch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. The driver pushes expected fetch
// addresses and instruction words into queues as it issues them; a monitor
// on the falling edge pops and compares whenever imem_req rises or
// fetch_done pulses. PC/ir expectations come from a small arithmetic model.
// Define FETCH_TIMEOUT_EN for both DUT and bench to exercise the timeout.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_f;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_addr_q[$];
  logic [31:0] exp_ir_q[$];

  // Reference model state
  logic [15:0] m_pc = 16'h0000;
  logic [31:0] m_ir = 32'h0000_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // PC update rule in plain integer arithmetic, wrapped modulo 2^16.
  function automatic logic [15:0] model_next(input logic sel, input logic br);
    int t;
    if (!sel)    t = int'(m_pc) + 1;
    else if (br) t = int'(m_ir[15:0]);
    else         t = int'(m_pc) + int'($signed(m_ir[15:0]));
    t = ((t % 65536) + 65536) % 65536;
    return 16'(t);
  endfunction

  // ---------------------------------------------------------------- monitor
  logic        prev_req  = 1'b0;
  logic        prev_done = 1'b0;
  logic [15:0] held_addr = 16'h0000;
  logic [31:0] mon_e;

  always @(negedge clk) begin
    if (bus.imem_req && !prev_req) begin
      if (exp_addr_q.size() == 0) begin
        chk("unexpected_req", 32'(bus.imem_req), 32'd0);
      end else begin
        mon_e = 32'(exp_addr_q.pop_front());
        chk("imem_addr", 32'(bus.imem_addr), mon_e);
        $display("req  addr=0x%04h", bus.imem_addr);
      end
      held_addr = bus.imem_addr;
    end else if (bus.imem_req) begin
      chk("addr_stable", 32'(bus.imem_addr), 32'(held_addr));
    end
    if (bus.fetch_done) begin
      chk("done_width", 32'(prev_done), 32'd0);
      if (exp_ir_q.size() == 0) begin
        chk("unexpected_done", 32'(bus.fetch_done), 32'd0);
      end else begin
        mon_e = exp_ir_q.pop_front();
        chk("ir", bus.ir, mon_e);
        chk("opcode", 32'(bus.opcode), 32'(mon_e[31:28]));
        chk("mm", 32'(bus.mm), 32'(mon_e[27:24]));
        chk("busy_in_done", 32'(bus.fetch_busy), 32'd1);
        $display("done ir=0x%08h opcode=%0d mm=%0d", bus.ir, bus.opcode, bus.mm);
      end
    end
    prev_req  = bus.imem_req;
    prev_done = bus.fetch_done;
  end

  // ---------------------------------------------------------------- driver
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pc_wr(input logic sel, input logic br);
    bus.pc_write = 1'b1;
    bus.pc_sel   = sel;
    bus.br_sel   = br;
    tick();
    bus.pc_write = 1'b0;
    m_pc = model_next(sel, br);
    chk("pc_write", 32'(bus.pc), 32'(m_pc));
    $display("pcwr sel=%0d br=%0d pc=0x%04h", sel, br, bus.pc);
  endtask

  task automatic fetch(input logic [31:0] data, input int waits, input logic noise,
                       input logic with_wr, input logic sel, input logic br);
    bus.ir_load = 1'b1;
    exp_addr_q.push_back(m_pc);
    if (with_wr) begin
      bus.pc_write = 1'b1;
      bus.pc_sel   = sel;
      bus.br_sel   = br;
    end
    tick();
    bus.ir_load  = 1'b0;
    bus.pc_write = 1'b0;
    if (with_wr) m_pc = model_next(sel, br);
    chk("req_after_load", 32'(bus.imem_req), 32'd1);
    chk("busy_in_req", 32'(bus.fetch_busy), 32'd1);
    for (int i = 0; i < waits; i++) begin
      if (noise) begin
        bus.ir_load  = 1'($urandom);
        bus.pc_write = 1'($urandom);
        bus.pc_sel   = 1'($urandom);
        bus.br_sel   = 1'($urandom);
      end
      bus.imem_rdata = $urandom;
      tick();
    end
    bus.ir_load    = 1'b0;
    bus.pc_write   = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = data;
    exp_ir_q.push_back(data);
    tick();
    bus.imem_ack = 1'b0;
    m_ir = data;
    chk("ir_after_ack", bus.ir, m_ir);
    chk("req_dropped", 32'(bus.imem_req), 32'd0);
    tick();
    chk("pc_after_fetch", 32'(bus.pc), 32'(m_pc));
    chk("busy_idle", 32'(bus.fetch_busy), 32'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    bus.pc_rst     = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_sel     = 1'b0;
    bus.br_sel     = 1'b0;
    bus.ir_load    = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    rst_f          = 1'b0;

    // Reset values, held while rst_f is low (an ack here must be ignored)
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hFFFF_FFFF;
    tick(); tick(); tick();
    bus.imem_ack = 1'b0;
    chk("rst_pc", 32'(bus.pc), 32'h0);
    chk("rst_ir", bus.ir, 32'h0);
    chk("rst_opcode", 32'(bus.opcode), 32'h0);
    chk("rst_req", 32'(bus.imem_req), 32'h0);
    chk("rst_addr", 32'(bus.imem_addr), 32'h0);
    chk("rst_done", 32'(bus.fetch_done), 32'h0);
    chk("rst_busy", 32'(bus.fetch_busy), 32'h0);
    chk("rst_err", 32'(bus.fetch_err), 32'h0);
    rst_f = 1'b1;
    tick();

    // First fetch: 3 wait cycles, word 0x81230004 from address 0
    fetch(32'h8123_0004, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("opcode_first", 32'(bus.opcode), 32'd8);
    chk("mm_first", 32'(bus.mm), 32'd1);

    // Absolute branch to 5, fetch offset 0xFFFE (with REQ noise), branches
    fetch(32'h0000_0005, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    pc_wr(1'b1, 1'b1);
    fetch(32'h1234_FFFE, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    pc_wr(1'b1, 1'b0);
    chk("rel_target", 32'(bus.pc), 32'h0003);
    pc_wr(1'b0, 1'b0);
    pc_wr(1'b0, 1'b0);
    pc_wr(1'b1, 1'b1);
    chk("abs_target", 32'(bus.pc), 32'hFFFE);
    pc_wr(1'b0, 1'b0);
    pc_wr(1'b0, 1'b0);
    chk("pc_wrap", 32'(bus.pc), 32'h0000);

    // pc_write and ir_load together: fetch from old PC, PC advances
    pc_wr(1'b0, 1'b0);
    fetch(32'h2200_0010, 2, 1'b0, 1'b1, 1'b0, 1'b0);

    // rst_f low during REQ, then a late ack
    bus.ir_load = 1'b1;
    exp_addr_q.push_back(m_pc);
    tick();
    bus.ir_load = 1'b0;
    tick(); tick();
    rst_f = 1'b0;
    tick();
    rst_f = 1'b1;
    m_pc = 16'h0; m_ir = 32'h0;
    chk("rst_mid_req", 32'(bus.imem_req), 32'd0);
    chk("rst_mid_pc", 32'(bus.pc), 32'h0);
    chk("rst_mid_ir", bus.ir, 32'h0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.imem_ack = 1'b0;
    tick();
    chk("late_ack_rst", bus.ir, m_ir);

    // pc_rst during REQ (with competing inputs), then a late ack
    pc_wr(1'b0, 1'b0);
    pc_wr(1'b0, 1'b0);
    fetch(32'h3300_0007, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.ir_load = 1'b1;
    exp_addr_q.push_back(m_pc);
    tick();
    bus.ir_load = 1'b0;
    tick();
    bus.pc_rst = 1'b1; bus.pc_write = 1'b1; bus.ir_load = 1'b1;
    tick();
    bus.pc_rst = 1'b0; bus.pc_write = 1'b0; bus.ir_load = 1'b0;
    m_pc = 16'h0;
    chk("pcrst_req", 32'(bus.imem_req), 32'd0);
    chk("pcrst_pc", 32'(bus.pc), 32'h0);
    chk("pcrst_ir", bus.ir, m_ir);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hCAFE_F00D;
    tick();
    bus.imem_ack = 1'b0;
    tick();
    chk("late_ack_pcrst", bus.ir, m_ir);
    $display("pcrst pc=0x%04h ir=0x%08h", bus.pc, bus.ir);

`ifdef FETCH_TIMEOUT_EN
    // No ack for 16 request cycles
    bus.ir_load = 1'b1;
    exp_addr_q.push_back(m_pc);
    tick();
    bus.ir_load = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_req_16th", 32'(bus.imem_req), 32'd1);
    chk("tmo_err_before", 32'(bus.fetch_err), 32'd0);
    tick();
    chk("tmo_req", 32'(bus.imem_req), 32'd0);
    chk("tmo_err", 32'(bus.fetch_err), 32'd1);
    chk("tmo_busy", 32'(bus.fetch_busy), 32'd0);
    chk("tmo_ir", bus.ir, m_ir);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1111_2222;
    tick();
    bus.imem_ack = 1'b0;
    tick(); tick();
    chk("tmo_sticky", 32'(bus.fetch_err), 32'd1);
    chk("tmo_late_ack", bus.ir, m_ir);
    bus.pc_rst = 1'b1;
    tick();
    bus.pc_rst = 1'b0;
    m_pc = 16'h0;
    chk("tmo_clear", 32'(bus.fetch_err), 32'd0);
    $display("tmo  err cleared pc=0x%04h", bus.pc);
`else
    // Request waits indefinitely; fetch_err stays 0
    bus.ir_load = 1'b1;
    exp_addr_q.push_back(m_pc);
    tick();
    bus.ir_load = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("nowait_req", 32'(bus.imem_req), 32'd1);
    chk("nowait_err", 32'(bus.fetch_err), 32'd0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h4455_6677;
    exp_ir_q.push_back(32'h4455_6677);
    tick();
    bus.imem_ack = 1'b0;
    m_ir = 32'h4455_6677;
    tick();
    chk("nowait_ir", bus.ir, m_ir);
`endif

    // Randomized mix of PC writes and fetches
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0: pc_wr(1'($urandom), 1'($urandom));
        1: fetch($urandom, int'($urandom_range(0, 6)), 1'($urandom), 1'b0, 1'b0, 1'b0);
        default: fetch($urandom, int'($urandom_range(0, 6)), 1'($urandom), 1'b1,
                       1'($urandom), 1'($urandom));
      endcase
    end

    tick(); tick();
    chk("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
    chk("ir_q_empty", 32'(exp_ir_q.size()), 32'd0);
    chk("final_pc", 32'(bus.pc), 32'(m_pc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have ports: clk  in  1  system clock, all state updates on rising edge.
REQ-002 The block SHALL have ports: rst_f  in  1  reset, synchronous, active-low.
REQ-003 The block SHALL have ports: pc_rst  in  1  clear PC to 0x0000 and abort any fetch.
REQ-004 The block SHALL have ports: pc_write  in  1  load next PC value.
REQ-005 The block SHALL have ports: pc_sel  in  1  0 = PC+1, 1 = branch target.
REQ-006 The block SHALL have ports: br_sel  in  1  0 = relative target (PC + ir[15:0]), 1 = absolute target (ir[15:0]).
REQ-007 The block SHALL have ports: ir_load  in  1  start instruction fetch from address PC.
REQ-008 The block SHALL have ports: imem_req  out  1  memory request, held until acknowledged.
REQ-009 The block SHALL have ports: imem_addr  out  16  fetch address.
REQ-010 The block SHALL have ports: imem_ack  in  1  read data valid this cycle.
REQ-011 The block SHALL have ports: imem_rdata  in  32  instruction word.
REQ-012 The block SHALL have ports: ir  out  32  instruction register; opcode  out  4  ir[31:28]; mm  out  4  ir[27:24].
REQ-013 The block SHALL have ports: pc  out  16  program counter; fetch_busy  out  1  fetch in progress; fetch_done  out  1  one-cycle completion pulse; fetch_err  out  1  sticky timeout flag.

Function
REQ-014 The FSM SHALL have states IDLE, REQ and DONE, encoded in 2 bits.
REQ-015 In IDLE, ir_load=1 SHALL move the FSM to REQ on the next edge and latch imem_addr from PC.
REQ-016 In REQ, imem_req SHALL be 1 and imem_addr SHALL stay constant.
REQ-017 In REQ, imem_ack=1 SHALL load imem_rdata into ir and move the FSM to DONE; imem_ack seen in IDLE or DONE SHALL be ignored.
REQ-018 DONE SHALL assert fetch_done for exactly one cycle and return to IDLE.
REQ-019 Fetch latency SHALL be 1 cycle from the ir_load edge to imem_req, plus the memory wait; ir SHALL be valid in the cycle fetch_done is high.
REQ-020 fetch_busy SHALL be 1 in REQ and DONE; ir_load while fetch_busy=1 SHALL be ignored.
REQ-021 pc_write=1 in IDLE SHALL update PC as follows: pc_sel=0 gives PC+1; pc_sel=1 and br_sel=1 gives ir[15:0]; pc_sel=1 and br_sel=0 gives PC+ir[15:0].
REQ-022 All PC arithmetic SHALL be 16-bit modulo 2^16 (0xFFFF+1 = 0x0000); the relative offset SHALL be treated as two's complement.
REQ-023 pc_write while fetch_busy=1 SHALL be ignored.
REQ-024 pc_write and ir_load in the same IDLE cycle SHALL update PC and fetch from the old PC.
REQ-025 pc_rst=1 SHALL take priority over all other inputs in any state: PC=0, FSM=IDLE, imem_req=0, fetch_err=0; ir SHALL be unchanged.

Reset
REQ-026 rst_f=0 at a rising edge SHALL set PC=0x0000, ir=0 (opcode NOOP), FSM=IDLE, imem_req=0, imem_addr=0, fetch_done=0, fetch_err=0.
REQ-027 Reset asserted mid-fetch SHALL drop imem_req on the same edge; a late imem_ack SHALL be ignored.
REQ-028 All outputs SHALL be registered and SHALL hold their reset values while rst_f=0.

Configuration
REQ-029 The timeout feature SHALL be compiled in when the macro FETCH_TIMEOUT_EN is defined, and compiled out otherwise.
REQ-030 With FETCH_TIMEOUT_EN defined: a 4-bit counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-031 With FETCH_TIMEOUT_EN defined, when 16 cycles pass without ack the block SHALL set fetch_err=1 (sticky), drop imem_req, go to IDLE, leave ir unchanged and not pulse fetch_done.
REQ-032 Without FETCH_TIMEOUT_EN, REQ SHALL wait indefinitely and fetch_err SHALL be tied to 0.

Verification
REQ-033 The bench SHALL cover: reset, then ir_load, then ack with imem_rdata=0x8123_0004 after 3 wait cycles -> imem_addr=0x0000, ir=0x81230004, opcode=8, mm=1, fetch_done pulses once.
REQ-034 The bench SHALL cover: PC=0x0005, ir[15:0]=0xFFFE, pc_sel=1, br_sel=0, pc_write -> PC=0x0003; the same case with br_sel=1 -> PC=0xFFFE.
REQ-035 The bench SHALL cover: PC=0xFFFF, pc_sel=0, pc_write -> PC=0x0000.
REQ-036 The bench SHALL cover: pc_write and ir_load asserted during REQ -> both ignored, imem_addr stable until ack.
REQ-037 The bench SHALL cover: rst_f=0 or pc_rst=1 during REQ -> imem_req=0 next cycle, later ack ignored, PC=0.
REQ-038 The bench SHALL cover, with FETCH_TIMEOUT_EN defined: no ack for 16 cycles -> fetch_err=1, imem_req=0, no fetch_done; then pc_rst -> fetch_err=0.
